regfile_mp: RTL

Parametrised multi-port register file for the MIPS datapath, generalising the two-read/one-write 32×32 file. It has N_RD registered read ports and N_WR write ports with fixed write priority, and an optional hard-wired zero register. An optional write-to-read bypass lets the decode stage see a value written in the same cycle without an extra forwarding mux.

---
 rtl/regfile_mp.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with registered read ports
//
// Purpose: register file for the MIPS datapath with N_RD registered read ports,
// N_WR write ports (higher port index wins on an address conflict) and an
// optional hard-wired zero register.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a read and a write
// to the same address at the same edge return the incoming write data.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-low reset (clears storage and read ports)
//   we      in   [N_WR]         per-port write enable
//   waddr   in   [N_WR*ADDR_W]  write address, port k at [k*ADDR_W +: ADDR_W]
//   wdata   in   [N_WR*DATA_W]  write data, port k at [k*DATA_W +: DATA_W]
//   re      in   [N_RD]         per-port read enable
//   raddr   in   [N_RD*ADDR_W]  read address, port j at [j*ADDR_W +: ADDR_W]
//   rdata   out  [N_RD*DATA_W]  registered read data, port j at [j*DATA_W +: DATA_W]
//   rvalid  out  [N_RD]         one-cycle pulse when rdata of port j was loaded
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_WR-1:0]          we,
  input  logic [N_WR*ADDR_W-1:0]   waddr,
  input  logic [N_WR*DATA_W-1:0]   wdata,
  input  logic [N_RD-1:0]          re,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  output logic [N_RD-1:0]          rvalid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_val [N_RD];

  // Value each read port will capture at the next edge.
  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      rd_val[j] = mem[raddr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest-numbered matching port is forwarded,
      // which is the same port whose data lands in storage.
      for (int k = 0; k < N_WR; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W])) begin
          rd_val[j] = wdata[k*DATA_W +: DATA_W];
        end
      end
`endif
      // Register 0 reads as zero even if a write to it is being forwarded.
      if ((ZERO_REG != 0) && (raddr[j*ADDR_W +: ADDR_W] == '0)) begin
        rd_val[j] = '0;
      end
    end
  end

  // Storage; later write ports override earlier ones on the same address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (we[k] && ((ZERO_REG == 0) || (waddr[k*ADDR_W +: ADDR_W] != '0))) begin
          mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registered read ports; rdata holds while re is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      for (int j = 0; j < N_RD; j++) begin
        rvalid[j] <= re[j];
        if (re[j]) begin
          rdata[j*DATA_W +: DATA_W] <= rd_val[j];
        end
      end
    end
  end

endmodule
